// File: rtl/spram_arbiter.sv
// spram_arbiter: two-master round-robin arbiter and command sequencer for the
// single-port RAM. One command is accepted per cycle. The RAM strobes are
// registered. Read data returns to the issuing master three cycles after its
// grant, with a tagged rvalid pulse. Per-master saturating grant counters are
// kept for debug.
module spram_arbiter #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              a_gnt,
  output logic              b_gnt,
  output logic              a_rvalid,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              ram_cs,
  output logic              ram_wr_en,
  output logic              ram_rd_en,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [CNT_W-1:0]  a_gnt_cnt,
  output logic [CNT_W-1:0]  b_gnt_cnt
);

  typedef enum logic {
    M_A = 1'b0,
    M_B = 1'b1
  } master_e;

  master_e             last;
  logic                gnt_any;
  logic                sel_we;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;
  master_e             sel_id;

  logic                tag1_v;
  master_e             tag1_id;
  logic                tag2_v;
  master_e             tag2_id;

  // Round-robin grant decision; gnt is held low while reset is asserted.
  always_comb begin
    a_gnt = 1'b0;
    b_gnt = 1'b0;
    if (reset_n) begin
      if (a_req && (!b_req || last == M_B)) begin
        a_gnt = 1'b1;
      end else if (b_req) begin
        b_gnt = 1'b1;
      end
    end
  end

  // Mux the granted master's command towards the command registers.
  always_comb begin
    gnt_any   = a_gnt | b_gnt;
    sel_id    = a_gnt ? M_A : M_B;
    sel_we    = a_gnt ? a_we : b_we;
    sel_addr  = a_gnt ? a_addr : b_addr;
    sel_wdata = a_gnt ? a_wdata : b_wdata;
  end

  // Priority pointer and registered RAM command strobes.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      last      <= M_B;
      ram_cs    <= 1'b0;
      ram_wr_en <= 1'b0;
      ram_rd_en <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
    end else if (gnt_any) begin
      last      <= sel_id;
      ram_cs    <= 1'b1;
      ram_wr_en <= sel_we;
      ram_rd_en <= !sel_we;
      ram_addr  <= sel_addr;
      ram_wdata <= sel_wdata;
    end else begin
      ram_cs    <= 1'b0;
      ram_wr_en <= 1'b0;
      ram_rd_en <= 1'b0;
    end
  end

  // Two-stage read tag pipeline that tracks the RAM's registered read.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tag1_v  <= 1'b0;
      tag1_id <= M_A;
      tag2_v  <= 1'b0;
      tag2_id <= M_A;
    end else begin
      tag1_v  <= gnt_any && !sel_we;
      tag1_id <= sel_id;
      tag2_v  <= tag1_v;
      tag2_id <= tag1_id;
    end
  end

  // Capture the RAM read data and pulse the rvalid of the tagged master.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rdata    <= '0;
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
    end else begin
      a_rvalid <= tag2_v && (tag2_id == M_A);
      b_rvalid <= tag2_v && (tag2_id == M_B);
      if (tag2_v) begin
        rdata <= ram_rdata;
      end
    end
  end

  // Saturating per-master grant counters.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      a_gnt_cnt <= '0;
      b_gnt_cnt <= '0;
    end else begin
      if (a_gnt && a_gnt_cnt != '1) begin
        a_gnt_cnt <= a_gnt_cnt + CNT_W'(1);
      end
      if (b_gnt && b_gnt_cnt != '1) begin
        b_gnt_cnt <= b_gnt_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_spram_arbiter.sv
// Testbench for spram_arbiter. It contains a behavioural single-port RAM with
// a registered read. Read responses are checked by a scoreboard queue that
// the stimulus fills when a read is granted. Expected data and grant order
// are hand-computed.
module tb_spram_arbiter;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              a_req, b_req, a_we, b_we;
  logic [ADDR_W-1:0] a_addr, b_addr;
  logic [DATA_W-1:0] a_wdata, b_wdata;
  logic              a_gnt, b_gnt, a_rvalid, b_rvalid;
  logic [DATA_W-1:0] rdata;
  logic              ram_cs, ram_wr_en, ram_rd_en;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic [CNT_W-1:0]  a_gnt_cnt, b_gnt_cnt;

  int unsigned checks   = 0;
  int unsigned failures = 0;
  int unsigned cyc      = 0;

  typedef struct {
    bit              m;
    logic [DATA_W-1:0] d;
    int unsigned     c;
  } exp_t;
  exp_t q[$];

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  spram_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .a_gnt(a_gnt), .b_gnt(b_gnt), .a_rvalid(a_rvalid), .b_rvalid(b_rvalid),
    .rdata(rdata), .ram_cs(ram_cs), .ram_wr_en(ram_wr_en), .ram_rd_en(ram_rd_en),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .a_gnt_cnt(a_gnt_cnt), .b_gnt_cnt(b_gnt_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // RAM model: registered read, write on cs & wr_en.
  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = '0;
    ram_rdata = '0;
  end
  always @(posedge clk) begin
    if (ram_cs && ram_wr_en) mem[ram_addr] <= ram_wdata;
    if (ram_cs && ram_rd_en) ram_rdata <= mem[ram_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Response monitor: pops the scoreboard on every rvalid pulse.
  always @(negedge clk) begin
    exp_t e;
    if (a_rvalid === 1'b1 && b_rvalid === 1'b1) begin
      checks++;
      failures++;
      $display("FAIL rvalid_both: a_rvalid and b_rvalid both high at cycle %0d", cyc);
    end else if (a_rvalid === 1'b1 || b_rvalid === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rvalid_unexpected: a=%0b b=%0b rdata=%0h at cycle %0d", a_rvalid, b_rvalid, rdata, cyc);
      end else begin
        e = q.pop_front();
        chk("rsp_master", {31'd0, b_rvalid}, {31'd0, e.m});
        chk("rsp_data", {24'd0, rdata}, {24'd0, e.d});
        chk("rsp_cycle", cyc, e.c);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    a_req = 1'b0;
    b_req = 1'b0;
    repeat (n) step();
  endtask

  // Present a command from master m and wait (bounded) for its grant.
  // Returns one cycle after the grant with the command still asserted.
  task automatic do_cmd(input bit m, input logic we, input logic [ADDR_W-1:0] addr,
                        input logic [DATA_W-1:0] wd, input bit resp,
                        input logic [DATA_W-1:0] exp_d);
    bit got = 1'b0;
    if (!m) begin
      a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = wd;
    end else begin
      b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = wd;
    end
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if ((!m && a_gnt === 1'b1) || (m && b_gnt === 1'b1)) begin
        got = 1'b1;
        if (!we && resp) q.push_back('{m: m, d: exp_d, c: cyc + 3});
      end
      step();
    end
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL grant_timeout: master %0d got no grant within 10 cycles", m);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0;
    a_req = 1'b1; b_req = 1'b1;
    a_we = 1'b1; b_we = 1'b1;
    a_addr = '0; b_addr = '0;
    a_wdata = 8'h11; b_wdata = 8'h22;

    // Reset with both requesting: no grant, all outputs cleared.
    repeat (2) begin
      @(negedge clk);
      chk("rst_a_gnt", {31'd0, a_gnt}, 0);
      chk("rst_b_gnt", {31'd0, b_gnt}, 0);
      step();
    end
    @(negedge clk);
    chk("rst_strobes", {29'd0, ram_cs, ram_wr_en, ram_rd_en}, 0);
    chk("rst_rvalid", {30'd0, a_rvalid, b_rvalid}, 0);
    chk("rst_addr", {28'd0, ram_addr}, 0);
    chk("rst_wdata", {24'd0, ram_wdata}, 0);
    chk("rst_rdata", {24'd0, rdata}, 0);
    chk("rst_cnt", {24'd0, a_gnt_cnt, b_gnt_cnt}, 0);
    step();
    reset_n = 1'b1;
    @(negedge clk);
    chk("first_contention_a", {31'd0, a_gnt}, 1);
    chk("first_contention_b", {31'd0, b_gnt}, 0);
    step();
    idle(2);

    // Single write then read by A.
    do_cmd(1'b0, 1'b1, 4'd3, 8'hA5, 1'b0, 8'h00);
    a_req = 1'b0;
    @(negedge clk);
    chk("wr_strobes", {29'd0, ram_cs, ram_wr_en, ram_rd_en}, 3'b110);
    chk("wr_addr", {28'd0, ram_addr}, 3);
    chk("wr_wdata", {24'd0, ram_wdata}, 8'hA5);
    step();
    do_cmd(1'b0, 1'b0, 4'd3, 8'h00, 1'b1, 8'hA5);
    a_req = 1'b0;
    @(negedge clk);
    chk("rd_strobes", {29'd0, ram_cs, ram_wr_en, ram_rd_en}, 3'b101);
    chk("rd_addr", {28'd0, ram_addr}, 3);
    step();
    @(negedge clk);
    chk("idle_strobes", {29'd0, ram_cs, ram_wr_en, ram_rd_en}, 0);
    chk("idle_addr_hold", {28'd0, ram_addr}, 3);
    step();
    idle(4);

    // Back-to-back write then read by B to the same address.
    do_cmd(1'b1, 1'b1, 4'd7, 8'h3C, 1'b0, 8'h00);
    do_cmd(1'b1, 1'b0, 4'd7, 8'h00, 1'b1, 8'h3C);
    idle(5);

    // Contention: both hold reads for 6 cycles; B was served last.
    a_req = 1'b1; a_we = 1'b0; a_addr = 4'd3;
    b_req = 1'b1; b_we = 1'b0; b_addr = 4'd7;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("cont_a_gnt", {31'd0, a_gnt}, (i % 2 == 0) ? 1 : 0);
      chk("cont_b_gnt", {31'd0, b_gnt}, (i % 2 == 1) ? 1 : 0);
      if (i % 2 == 0) q.push_back('{m: 1'b0, d: 8'hA5, c: cyc + 3});
      else            q.push_back('{m: 1'b1, d: 8'h3C, c: cyc + 3});
      step();
    end
    idle(5);
    @(negedge clk);
    chk("cnt_a", {28'd0, a_gnt_cnt}, 6);
    chk("cnt_b", {28'd0, b_gnt_cnt}, 5);
    chk("rdata_hold", {24'd0, rdata}, 8'h3C);
    step();

    // Reset while a read is in flight: no response may appear.
    do_cmd(1'b0, 1'b0, 4'd3, 8'h00, 1'b0, 8'h00);
    a_req = 1'b0;
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    repeat (5) step();
    @(negedge clk);
    chk("midrst_rdata", {24'd0, rdata}, 0);
    chk("midrst_cnt", {24'd0, a_gnt_cnt, b_gnt_cnt}, 0);
    chk("midrst_rvalid", {30'd0, a_rvalid, b_rvalid}, 0);
    step();

    // Saturation: 20 back-to-back solo writes by A.
    a_req = 1'b1; a_we = 1'b1; a_addr = 4'd9; a_wdata = 8'h5A;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("sat_gnt", {31'd0, a_gnt}, 1);
      if (i == 10) chk("sat_cnt_mid", {28'd0, a_gnt_cnt}, 10);
      step();
    end
    a_req = 1'b0;
    @(negedge clk);
    chk("sat_cnt_a", {28'd0, a_gnt_cnt}, 15);
    chk("sat_cnt_b", {28'd0, b_gnt_cnt}, 0);
    step();
    idle(4);

    chk("scoreboard_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spram_arbiter.md
# spram_arbiter

Two-requester round-robin arbiter and sequencer for the team's single-port RAM (`single_port_ram`, registered read, mutually exclusive wr_en/rd_en). It lets two independent masters (A, B) share the one RAM port. It accepts at most one command per cycle, drives the RAM's cs/wr_en/rd_en/address/data strobes from registers, and routes read data back to the issuing master with a tagged valid. It also keeps saturating per-master grant counters for debug.

## Interface
- DATA_W, default 8: data width; must match the RAM's data_size.
- ADDR_W, default 4: address width; must match the RAM's address_size.
- CNT_W, default 16: grant counter width.
- clk, input, 1: sole clock; all state updates on posedge.
- reset_n, input, 1: synchronous, active-low reset, sampled on posedge clk.
- a_req / b_req, input, 1: command request; held with its command until granted.
- a_we / b_we, input, 1: 1 = write, 0 = read.
- a_addr / b_addr, input, ADDR_W: command address.
- a_wdata / b_wdata, input, DATA_W: write data.
- a_gnt / b_gnt, output, 1: one-cycle grant pulse; the command is accepted this cycle.
- a_rvalid / b_rvalid, output, 1: one-cycle pulse; the read data is on rdata.
- rdata, output, DATA_W: registered read data, shared by both masters.
- ram_cs, ram_wr_en, ram_rd_en, output, 1: RAM strobes, registered.
- ram_addr, output, ADDR_W: RAM address, registered.
- ram_wdata, output, DATA_W: RAM data_in, registered.
- ram_rdata, input, DATA_W: RAM data_out.
- a_gnt_cnt / b_gnt_cnt, output, CNT_W: saturating grant counts.

## Operation
- Arbitration is combinational each cycle from a_req, b_req and the priority pointer `last` (0 = A served last, 1 = B served last).
  - Only one requester: it is granted.
  - Both requesting: the master not served last is granted.
  - Neither requesting: no grant.
- Exactly one of a_gnt/b_gnt is high per grant cycle, never both.
- On a grant edge:
  - `last` updates to the granted master.
  - The command registers load: ram_cs=1, ram_wr_en=we, ram_rd_en=!we, ram_addr=addr, ram_wdata=wdata.
- With no grant, ram_cs, ram_wr_en and ram_rd_en register 0. ram_addr and ram_wdata hold their values.
- ram_wr_en and ram_rd_en are never both 1.
- Read tag pipeline, 2 stages, each stage holding {valid, master id}:
  - Stage 1 loads on a read grant.
  - Stage 2 loads from stage 1.
  - When stage 2 is valid: rdata <= ram_rdata, and the rvalid of the tagged master pulses for one cycle.
- rdata holds its last value when no rvalid is pulsing.
- Writes produce no response.
- Grant counters increment on each grant of their master and saturate at 2^CNT_W-1; no wrap.
- A master seeing gnt high may present a new command in the next cycle. Back-to-back commands are permitted.

## Timing
- Grant in cycle T, both reads and writes:
  - RAM strobes asserted during T+1.
  - RAM captures at the posedge ending T+1.
- Read data:
  - ram_rdata valid during T+2.
  - a_rvalid/b_rvalid and rdata valid during T+3.
  - Fixed read latency is 3 cycles from gnt.
- Throughput: one command per cycle sustained; rvalid pulses are in grant order.
- Write followed by read to the same address in consecutive grants: the read returns the new data, because the RAM write completes before the read strobe is presented.
- Reset, when reset_n=0 at a posedge, clears:
  - All outputs: gnt, rvalid, ram_cs/wr_en/rd_en = 0; ram_addr, ram_wdata, rdata = 0; counters = 0.
  - `last` = 1, so A wins the first contention.
  - Both tag stages invalid.
  - gnt is also forced 0 combinationally while reset_n=0.
- Reset mid-operation: in-flight reads are dropped and no rvalid is issued for them. Masters must re-request after reset.
- A master that drops req before gnt: the command is withdrawn and the arbiter does not act on it.

## Test plan
- Reset check: reset_n low for 2 cycles with both req high -> no gnt; all outputs 0; first post-reset contention grants A.
- Single write/read: A writes addr 3 = 0xA5 (grant at T) -> ram_cs=1, ram_wr_en=1, ram_addr=3 during T+1. A reads addr 3, granted at T' -> a_rvalid=1, rdata=0xA5 at T'+3, b_rvalid stays 0.
- Contention: A and B both hold read requests for 6 cycles -> grants alternate A,B,A,B,A,B; rvalid pulses follow the same order, each 3 cycles after its grant.
- Back-to-back RAW: B writes addr 7 = 0x3C, then reads addr 7 in the next cycle -> b_rvalid with rdata=0x3C.
- Reset mid-flight: a read granted at T, reset_n low at T+1 -> no rvalid at T+3; rdata=0; counters=0.
- Saturation: with CNT_W=4, give A 20 solo grants -> a_gnt_cnt stops at 15; b_gnt_cnt=0.
